spi_cmd_arbiter: RTL and testbench

//  Shares the command-register write port (servo/motor/digital command regs, addresses 25..40)

---
 rtl/spi_regmap_pkg.sv | 20 ++
 rtl/spi_cmd_arbiter_if.sv | 34 +++
 rtl/rr_pick.sv | 31 +++
 rtl/spi_cmd_arbiter.sv | 149 ++++++++++++++
 tb/tb_spi_cmd_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_regmap_pkg.sv
// Command register map constants and arbiter FSM encoding.
// Shared by spi_cmd_arbiter, its interface and rr_pick.
package spi_regmap_pkg;

   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 16;

   // Writable command register window (servo/motor/digital)
   localparam int unsigned WR_LO = 25;
   localparam int unsigned WR_HI = 40;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOCK  = 2'd1;
   localparam logic [1:0] ST_BLOCK = 2'd2;

   function automatic logic addr_ok(input logic [31:0] a);
      return (a >= WR_LO) && (a <= WR_HI);
   endfunction

endpackage

// File: rtl/spi_cmd_arbiter_if.sv
// Requester/command-bank bus of spi_cmd_arbiter.
// master: requesters (req, req_addr, req_data, lock0 out; grant/write in).
// slave : arbiter (requests in; gnt, wr_en, wr_addr, wr_data,
//         lock_timeout, wr_err out).
interface spi_cmd_arbiter_if
   import spi_regmap_pkg::*;
#(
   parameter int NREQ   = 3,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic [NREQ-1:0]        req;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*DATA_W-1:0] req_data;
   logic                   lock0;
   logic [NREQ-1:0]        gnt;
   logic                   wr_en;
   logic [ADDR_W-1:0]      wr_addr;
   logic [DATA_W-1:0]      wr_data;
   logic                   lock_timeout;
   logic                   wr_err;

   modport master (
      output req, req_addr, req_data, lock0,
      input  gnt, wr_en, wr_addr, wr_data, lock_timeout, wr_err
   );

   modport slave (
      input  req, req_addr, req_data, lock0,
      output gnt, wr_en, wr_addr, wr_data, lock_timeout, wr_err
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req_i at or after
// ptr_i (wrapping), as one-hot, index and valid. Ports: req_i, ptr_i, onehot_o, idx_o, valid_o.
module rr_pick #(
   parameter int N  = 3,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  onehot_o,
   output logic [PW-1:0] idx_o,
   output logic          valid_o
);

   int j;

   always_comb begin
      onehot_o = '0;
      idx_o    = '0;
      valid_o  = 1'b0;
      j        = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr_i) + k) % N;
         if (!valid_o && req_i[j]) begin
            valid_o     = 1'b1;
            onehot_o[j] = 1'b1;
            idx_o       = PW'(j);
         end
      end
   end

endmodule

// File: rtl/spi_cmd_arbiter.sv
// Round-robin arbiter for the command-register write port with SPI
// burst lock (requester 0) and lock timeout; one registered write per cycle.
// Ports: SYS_CLK, SYS_RST_N (async, active low), bus (spi_cmd_arbiter_if.slave).
// Option: define SPI_ARB_WPROT_EN to reject writes outside [WR_LO, WR_HI] with wr_err.
module spi_cmd_arbiter
   import spi_regmap_pkg::*;
#(
   parameter int NREQ     = 3,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int LOCK_MAX = 1024
) (
   input logic              SYS_CLK,
   input logic              SYS_RST_N,
   spi_cmd_arbiter_if.slave bus
);

   localparam int PTR_W = $clog2(NREQ);
   localparam int CNT_W = $clog2(LOCK_MAX);
   localparam logic [NREQ-1:0] REQ0 = {{(NREQ-1){1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

   logic [1:0]        state_q, state_d;
   logic [PTR_W-1:0]  rr_q, rr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              tmo_q, tmo_d;
   logic              err_q, err_d;

   logic              lock_only;
   logic [NREQ-1:0]   elig;
   logic [NREQ-1:0]   win;
   logic [PTR_W-1:0]  win_idx;
   logic              win_v;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic              in_range;

   // Lock wins over other requests already on the edge lock0 is first seen.
   assign lock_only = (state_q == ST_LOCK) ||
                      ((state_q == ST_IDLE) && bus.lock0);

   // The requester granted this cycle sits out the next decision.
   always_comb begin
      elig = bus.req & ~gnt_q;
      if (lock_only) elig = elig & REQ0;
   end

   rr_pick #(
      .N  (NREQ),
      .PW (PTR_W)
   ) u_pick (
      .req_i    (elig),
      .ptr_i    (rr_q),
      .onehot_o (win),
      .idx_o    (win_idx),
      .valid_o  (win_v)
   );

   assign sel_addr = bus.req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
   assign sel_data = bus.req_data[int'(win_idx)*DATA_W +: DATA_W];

`ifdef SPI_ARB_WPROT_EN
   assign in_range = addr_ok(32'(sel_addr));
`else
   assign in_range = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      gnt_d   = win;
      wr_en_d = win_v & in_range;
      err_d   = win_v & ~in_range;
      addr_d  = win_v ? sel_addr : addr_q;
      data_d  = win_v ? sel_data : data_q;
      tmo_d   = 1'b0;

      // Locked grants to the SPI host leave the rotation untouched.
      if (win_v && !lock_only)
         rr_d = (win_idx == PTR_LAST) ? '0 : win_idx + 1'b1;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.lock0) begin
               state_d = ST_LOCK;
               cnt_d   = '0;
            end
         end
         ST_LOCK: begin
            if (!bus.lock0) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_BLOCK;
               tmo_d   = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_BLOCK: begin
            // Stuck lock0 is ignored until the host releases it.
            if (!bus.lock0) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
      if (!SYS_RST_N) begin
         state_q <= ST_IDLE;
         rr_q    <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         wr_en_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         tmo_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         wr_en_q <= wr_en_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
      end
   end

   assign bus.gnt          = gnt_q;
   assign bus.wr_en        = wr_en_q;
   assign bus.wr_addr      = addr_q;
   assign bus.wr_data      = data_q;
   assign bus.lock_timeout = tmo_q;
   assign bus.wr_err       = err_q;

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Scoreboard bench for spi_cmd_arbiter (NREQ=3, LOCK_MAX=16).
// Requester models drive req from per-port queues; a monitor checks outputs.
module tb_spi_cmd_arbiter;

   localparam int NREQ     = 3;
   localparam int ADDR_W   = 10;
   localparam int DATA_W   = 16;
   localparam int LOCK_MAX = 16;

`ifdef SPI_ARB_WPROT_EN
   localparam bit WP = 1'b1;
`else
   localparam bit WP = 1'b0;
`endif

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } item_t;

   typedef struct packed {
      logic              tmo;
      logic [NREQ-1:0]   gnt;
      logic              en;
      logic              err;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } exp_t;

   logic clk;
   logic rst_n;

   item_t rq [NREQ][$];
   exp_t  sbq [$];
   int    vectors;
   int    miscompares;

   spi_cmd_arbiter_if #(
      .NREQ   (NREQ),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) bus ();

   spi_cmd_arbiter #(
      .NREQ     (NREQ),
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .LOCK_MAX (LOCK_MAX)
   ) dut (
      .SYS_CLK   (clk),
      .SYS_RST_N (rst_n),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // Requester models: drop an item once granted, present the next one.
   initial begin
      logic [NREQ-1:0]        r;
      logic [NREQ*ADDR_W-1:0] a;
      logic [NREQ*DATA_W-1:0] d;
      bus.req      = '0;
      bus.req_addr = '0;
      bus.req_data = '0;
      forever begin
         @(negedge clk);
         r = '0;
         a = '0;
         d = '0;
         for (int i = 0; i < NREQ; i++) begin
            if (bus.gnt[i] && rq[i].size() != 0) rq[i].delete(0);
            if (rq[i].size() != 0) begin
               r[i] = 1'b1;
               a[i*ADDR_W +: ADDR_W] = rq[i][0].a;
               d[i*DATA_W +: DATA_W] = rq[i][0].d;
            end
         end
         bus.req      = r;
         bus.req_addr = a;
         bus.req_data = d;
      end
   end

   task automatic check_out(input bit tmo);
      exp_t e;
      vectors++;
      if (sbq.size() == 0) begin
         $display("FAIL unexpected: tmo=%0b gnt=%b addr=%0d, required no output",
                  tmo, bus.gnt, bus.wr_addr);
         miscompares++;
         return;
      end
      e = sbq.pop_front();
      if (tmo) begin
         if (!e.tmo) begin
            $display("FAIL order: lock_timeout seen, required grant gnt=%b addr=%0d",
                     e.gnt, e.addr);
            miscompares++;
         end
      end else if (e.tmo || bus.gnt !== e.gnt || bus.wr_en !== e.en ||
                   bus.wr_err !== e.err || bus.wr_addr !== e.addr ||
                   bus.wr_data !== e.data) begin
         $display({"FAIL grant: got tmo=0 gnt=%b en=%0b err=%0b addr=%0d data=%h,",
                   " required tmo=%0b gnt=%b en=%0b err=%0b addr=%0d data=%h"},
                  bus.gnt, bus.wr_en, bus.wr_err, bus.wr_addr, bus.wr_data,
                  e.tmo, e.gnt, e.en, e.err, e.addr, e.data);
         miscompares++;
      end
   endtask

   // Monitor
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.lock_timeout) check_out(1'b1);
            if (bus.gnt != '0) begin
               check_out(1'b0);
            end else if (bus.wr_en || bus.wr_err) begin
               $display("FAIL strobe: wr_en=%0b wr_err=%0b without gnt, required 0",
                        bus.wr_en, bus.wr_err);
               miscompares++;
            end
         end
      end
   end

   task automatic put(input int i, input int a, input int d);
      item_t it;
      it.a = ADDR_W'(a);
      it.d = DATA_W'(d);
      rq[i].push_back(it);
   endtask

   task automatic exp_g(input int i, input int a, input int d, input bit err);
      exp_t e;
      e.tmo  = 1'b0;
      e.gnt  = NREQ'(1 << i);
      e.en   = ~err;
      e.err  = err;
      e.addr = ADDR_W'(a);
      e.data = DATA_W'(d);
      sbq.push_back(e);
   endtask

   task automatic exp_t_pulse();
      exp_t e;
      e = '0;
      e.tmo = 1'b1;
      sbq.push_back(e);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         $display("FAIL %s: got %0h, required %0h", name, act, req);
         miscompares++;
      end
   endtask

   task automatic sync();
      @(posedge clk);
      #2;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((sbq.size() != 0 || rq[0].size() != 0 || rq[1].size() != 0 ||
              rq[2].size() != 0) && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (n >= budget) begin
         $display("FAIL drain: %0d outputs still pending, required 0", sbq.size());
         miscompares++;
      end
      repeat (3) @(posedge clk);
      #2;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      bus.lock0   = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs",
          {bus.gnt, bus.wr_en, bus.wr_addr, bus.wr_data, bus.lock_timeout, bus.wr_err}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      sync();

      // All three requesting: rotation 0,1,2,0,1,2
      for (int k = 0; k < 2; k++)
         for (int r = 0; r < NREQ; r++)
            put(r, 26 + 4*r + k, 16'h1000*(r+1) + k);
      for (int k = 0; k < 2; k++)
         for (int r = 0; r < NREQ; r++)
            exp_g(r, 26 + 4*r + k, 16'h1000*(r+1) + k, 1'b0);
      drain(40);

      // Single write, one cycle latency
      put(1, 33, 16'h0400);
      exp_g(1, 33, 16'h0400, 1'b0);
      @(posedge clk);
      #1;
      chk("latency_gnt", bus.gnt, 3'b010);
      chk("latency_wr_en", bus.wr_en, 1);
      drain(20);

      // Burst lock: req0 only until lock0 drops, then req2
      bus.lock0 = 1'b1;
      put(0, 27, 16'h0a01);
      put(0, 28, 16'h0a02);
      put(0, 29, 16'h0a03);
      put(2, 30, 16'h0b00);
      exp_g(0, 27, 16'h0a01, 1'b0);
      exp_g(0, 28, 16'h0a02, 1'b0);
      exp_g(0, 29, 16'h0a03, 1'b0);
      exp_g(2, 30, 16'h0b00, 1'b0);
      repeat (8) @(posedge clk);
      #2;
      bus.lock0 = 1'b0;
      drain(20);

      // Lock held LOCK_MAX+5 cycles: timeout, then rotation despite lock0
      bus.lock0 = 1'b1;
      put(1, 31, 16'h0c01);
      put(2, 32, 16'h0c02);
      exp_t_pulse();
      exp_g(1, 31, 16'h0c01, 1'b0);
      exp_g(2, 32, 16'h0c02, 1'b0);
      repeat (16) @(posedge clk);
      #1;
      chk("timeout_early", bus.lock_timeout, 0);
      @(posedge clk);
      #1;
      chk("timeout_pulse", bus.lock_timeout, 1);
      @(posedge clk);
      #1;
      chk("timeout_width", bus.lock_timeout, 0);
      repeat (3) @(posedge clk);
      #1;
      bus.lock0 = 1'b0;
      drain(20);

      // Address window edges
      put(1, 5, 16'h0d05);
      put(1, 40, 16'h0d28);
      put(1, 25, 16'h0d19);
      put(1, 41, 16'h0d29);
      exp_g(1, 5, 16'h0d05, WP);
      exp_g(1, 40, 16'h0d28, 1'b0);
      exp_g(1, 25, 16'h0d19, 1'b0);
      exp_g(1, 41, 16'h0d29, WP);
      drain(40);

      // Reset while locked with a grant on the bus
      bus.lock0 = 1'b1;
      put(0, 35, 16'h0e00);
      exp_g(0, 35, 16'h0e00, 1'b0);
      @(posedge clk);
      @(negedge clk);
      #1;
      rst_n     = 1'b0;
      bus.lock0 = 1'b0;
      for (int i = 0; i < NREQ; i++) rq[i].delete();
      #1;
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_wr_en", bus.wr_en, 0);
      chk("rst_wr_addr", bus.wr_addr, 0);
      chk("rst_wr_data", bus.wr_data, 0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      sync();

      // After reset: IDLE and rotation restarts at 0
      put(0, 36, 16'h0f00);
      put(1, 37, 16'h0f01);
      put(2, 38, 16'h0f02);
      exp_g(0, 36, 16'h0f00, 1'b0);
      exp_g(1, 37, 16'h0f01, 1'b0);
      exp_g(2, 38, 16'h0f02, 1'b0);
      drain(20);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
